// File: rtl/compare_pkg.sv
// Shared types and helpers for the LSB-first serial magnitude comparator.
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    localparam int CMP_WIDTH_DEFAULT = 4;

    function automatic int cmp_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_cmp_step.sv
// One bit-step of the LSB-first compare. Define COMPARE_SERIAL_SIGNED_EN to
// treat the MSB step as a two's-complement sign bit.
module serial_cmp_step (
    input  logic ai,
    input  logic bi,
    input  logic gt_in,
    input  logic eq_in,
    input  logic msb_step,
    output logic gt_out,
    output logic eq_out
);

    logic w_diff;
    logic w_gt_bit;

    assign w_diff = ai ^ bi;

`ifdef COMPARE_SERIAL_SIGNED_EN
    // A set sign bit on A makes A the smaller operand.
    assign w_gt_bit = msb_step ? bi : ai;
`else
    logic w_unused_msb;
    assign w_unused_msb = msb_step;
    assign w_gt_bit     = ai;
`endif

    // Later (higher-order) differences override whatever lower bits decided.
    assign gt_out = w_diff ? w_gt_bit : gt_in;
    assign eq_out = eq_in & ~w_diff;

endmodule

// File: rtl/compare_serial_lsb.sv
// Bit-serial LSB-first magnitude comparator with valid/ready on both sides.
// Optional signed compare: define COMPARE_SERIAL_SIGNED_EN.
module compare_serial_lsb
    import compare_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_greater_b,
    output logic             a_equal_b,
    output logic             a_less_b,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic             dbg_eq
);

    localparam int CNT_W = cmp_cnt_w(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid only in DONE, and the flags
    // hold steady there until out_ready is seen.
    cmp_state_t        r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_gt;
    logic              r_eq;

    logic              w_last;
    logic              w_gt_next;
    logic              w_eq_next;
    logic              w_done;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    serial_cmp_step u_step (
        .ai       (r_a[0]),
        .bi       (r_b[0]),
        .gt_in    (r_gt),
        .eq_in    (r_eq),
        .msb_step (w_last),
        .gt_out   (w_gt_next),
        .eq_out   (w_eq_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_gt    <= 1'b0;
                        r_eq    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_gt  <= w_gt_next;
                    r_eq  <= w_eq_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_done      = (r_state == DONE);
    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state == SCAN);
    assign out_valid   = w_done;
    assign a_greater_b = w_done & r_gt;
    assign a_equal_b   = w_done & r_eq;
    assign a_less_b    = w_done & ~r_gt & ~r_eq;
    assign dbg_state   = r_state;
    assign dbg_eq      = r_eq;

endmodule

// File: tb/tb_compare_serial_lsb.sv
// Directed bench for compare_serial_lsb (WIDTH=4); expectations follow
// COMPARE_SERIAL_SIGNED_EN when the build defines it.
module tb_compare_serial_lsb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         a_greater_b;
    logic         a_equal_b;
    logic         a_less_b;
    logic         busy;
    logic [1:0]   dbg_state;
    logic         dbg_eq;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        string        name;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   exp_flags; // {gt, eq, lt}
    } vec_t;

    vec_t vecs[$];

    compare_serial_lsb #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a_greater_b (a_greater_b),
        .a_equal_b   (a_equal_b),
        .a_less_b    (a_less_b),
        .busy        (busy),
        .dbg_state   (dbg_state),
        .dbg_eq      (dbg_eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {a_greater_b, a_equal_b, a_less_b};
    endfunction

    // Handshake at the next posedge; returns on the negedge right after it.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        check("in_ready_before_hs", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~va;
        b        = ~vb;
    endtask

    // Count edges from the handshake until out_valid, bounded.
    task automatic wait_result(output int edges);
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   edges;
        logic [2:0] exp;
        exp_q.push_back(v.exp_flags);
        send(v.va, v.vb);
        check({v.name, "_busy"}, busy, 1);
        check({v.name, "_flags_scan"}, flags(), 3'b000);
        wait_result(edges);
        check({v.name, "_latency"}, edges, W);
        exp = exp_q.pop_front();
        check({v.name, "_flags"}, flags(), exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({v.name, "_out_valid_drop"}, out_valid, 0);
        check({v.name, "_idle_ready"}, in_ready, 1);
    endtask

    function automatic vec_t mk(input string n, input logic [W-1:0] va,
                                input logic [W-1:0] vb, input logic [2:0] f);
        vec_t v;
        v.name = n; v.va = va; v.vb = vb; v.exp_flags = f;
        return v;
    endfunction

    initial begin
        int edges;
        int ov_cycles;
        logic [2:0] held;

        // Outcome of the sign-sensitive vectors.
`ifdef COMPARE_SERIAL_SIGNED_EN
        localparam logic [2:0] F_8_1  = 3'b001; // -8 < 1
        localparam logic [2:0] F_7_8  = 3'b100; // 7 > -8
        localparam logic [2:0] F_15_0 = 3'b001; // -1 < 0
        localparam logic [2:0] F_0_15 = 3'b100;
        localparam logic [2:0] F_A_7  = 3'b001; // -6 < 7
`else
        localparam logic [2:0] F_8_1  = 3'b100;
        localparam logic [2:0] F_7_8  = 3'b001;
        localparam logic [2:0] F_15_0 = 3'b100;
        localparam logic [2:0] F_0_15 = 3'b001;
        localparam logic [2:0] F_A_7  = 3'b100;
`endif

        vecs.push_back(mk("a1010_b0111", 4'b1010, 4'b0111, F_A_7));
        vecs.push_back(mk("eq9",         4'd9,    4'd9,    3'b010));
        vecs.push_back(mk("lt3_12",      4'd3,    4'd12,   3'b001));
        vecs.push_back(mk("lsb_override",4'b0110, 4'b0101, 3'b100));
        vecs.push_back(mk("msb8_1",      4'b1000, 4'b0001, F_8_1));
        vecs.push_back(mk("b7_8",        4'd7,    4'd8,    F_7_8));
        vecs.push_back(mk("lsb_only",    4'd1,    4'd0,    3'b100));
        vecs.push_back(mk("zero_15",     4'd0,    4'd15,   F_0_15));
        vecs.push_back(mk("eq0",         4'd0,    4'd0,    3'b010));

        // Reset and idle
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", flags(), 3'b000);
        check("rst_eq_reg", dbg_eq, 1);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure with an ignored operand pulse
        send(4'd3, 4'd12);
        wait_result(edges);
        check("bp_latency", edges, W);
        held = flags();
        check("bp_flags", held, 3'b001);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            a = 4'd15;
            b = 4'd0;
            @(negedge clk);
            check("bp_out_valid_hold", out_valid, 1);
            check("bp_flags_hold", flags(), 3'b001);
            check("bp_in_ready_low", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", out_valid, 0);
        @(negedge clk);
        check("bp_no_new_scan", busy, 0);
        check("bp_still_idle", in_ready, 1);

        // out_ready already high when DONE is entered
        out_ready = 1'b1;
        send(4'd5, 4'd2);
        ov_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ov_cycles++;
                check("or_high_flags", flags(), 3'b100);
            end
        end
        out_ready = 1'b0;
        check("or_high_one_cycle", ov_cycles, 1);

        // Reset two cycles after the handshake
        send(4'd9, 4'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_eq_reg", dbg_eq, 1);
        @(negedge clk);
        rst = 1'b0;
        ov_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ov_cycles++;
        end
        check("mid_rst_no_spurious", ov_cycles, 0);
        run_vec(mk("post_rst_15_0", 4'd15, 4'd0, F_15_0));

        // Reset while a result is waiting in DONE
        send(4'd2, 4'd2);
        wait_result(edges);
        check("done_rst_pre", out_valid, 1);
        rst = 1'b1;
        #1;
        check("done_rst_out_valid", out_valid, 0);
        check("done_rst_flags", flags(), 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(mk("post_done_rst", 4'd6, 4'd6, 3'b010));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/compare_serial_lsb.md
Name: compare_serial_lsb

Overview:
- Sequential magnitude comparator. Accepts two WIDTH-bit operands through a valid/ready handshake.
- Scans the operands bit-serially from LSB to MSB, one bit per clock. This is the opposite scan direction to our MSB-first cascaded comparators.
- Returns greater/equal/less flags through a valid/ready output handshake.
- Used where area matters more than latency, e.g. threshold checks in slow control paths.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result flags valid.
- out_ready  input  1  consumer accepts result.
- a_greater_b  output  1  A > B.
- a_equal_b  output  1  A == B.
- a_less_b  output  1  A < B.
- busy  output  1  scan in progress (SCAN state).

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, all three flags=0. Internal shift registers, bit counter, gt and eq are cleared; eq resets to 1.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready, latch a and b into shift registers, set eq=1, gt=0, cnt=0, and go to SCAN.
  - SCAN: busy=1, in_ready=0. Each cycle examine bit 0 of each shift register (ai, bi), then shift both right by 1.
    - If ai!=bi: gt <= ai (a higher-order difference overrides any lower one); eq <= 0.
    - If ai==bi: gt and eq hold.
    - cnt increments each cycle. When cnt==WIDTH-1, register the final flags and go to DONE.
  - DONE: out_valid=1. Flags hold stable while out_valid=1 and out_ready=0. When out_ready=1, go to IDLE; out_valid drops on the next edge.
- Flags are one-hot in DONE: a_less_b = ~gt & ~eq. Outside DONE all three flags read 0.
- Latency: handshake at edge T, scan edges T+1..T+WIDTH, out_valid=1 from T+WIDTH.
  - For WIDTH=4: accept at edge 0, result visible after edge 4.
- Throughput: one comparison per WIDTH+2 cycles minimum. There is no overlap; in_ready=0 in SCAN and DONE.
- in_valid is ignored outside IDLE. a and b are sampled only at the handshake edge; later changes have no effect.
- If out_ready is held high on entry to DONE, out_valid is still asserted for exactly one cycle.
- rst asserted mid-SCAN or mid-DONE: immediate return to reset values, with no spurious out_valid. The first handshake after reset release is processed normally.
- The counter is $clog2(WIDTH) bits and must not wrap before DONE.

Optional Feature:
- Macro: COMPARE_SERIAL_SIGNED_EN.
- Defined: operands are two's complement. On the MSB step (cnt==WIDTH-1), if ai!=bi then gt <= bi, because a negative A is smaller.
- Undefined: unsigned compare on every bit, MSB included.
- eq behaviour is identical in both builds.

Decomposition:
- Package compare_pkg holds:
  - enum cmp_state_t {IDLE, SCAN, DONE}.
  - Localparam CMP_WIDTH_DEFAULT=4.
  - A function cmp_cnt_w(width) returning $clog2(width).
- One natural sub-module: serial_cmp_step. It is combinational: inputs ai, bi, gt_in, eq_in, msb_step; outputs gt_out, eq_out. The signed rule sits under the macro here.
- The top level holds the FSM, shift registers, counter and handshakes.

Test Plan:
- Reset and idle: rst pulse → in_ready=1, out_valid=0, busy=0, flags 000; eq register reads 1.
- Unsigned, WIDTH=4:
  - a=4'b1010, b=4'b0111 → gt=1, eq=0, lt=0, with out_valid high exactly 4 edges after the handshake.
  - a=9, b=9 → eq=1.
  - a=3, b=12 → lt=1.
- LSB-override check: a=4'b0110, b=4'b0101 → gt=1. The bit-0 difference favours B but the later bit-1 difference favours A.
- Backpressure: hold out_ready=0 for 5 cycles after DONE → flags stable, out_valid stays 1. Pulse in_valid with a new operand during this time → ignored.
- Signed build (COMPARE_SERIAL_SIGNED_EN): a=4'b1000 (-8), b=4'b0001 → lt=1. The same stimulus in the unsigned build → gt=1.
- Reset mid-scan: assert rst 2 cycles after the handshake → no out_valid. A new handshake with a=15, b=0 → gt=1 with normal latency.
